// File: rtl/bus_compare_ctrl.sv
// bus_compare_ctrl
//   Sequencing controller for the dual-channel bus comparator. Words from the
//   redundant channels A and B are buffered in one small FIFO per channel and
//   paired in arrival order. Each pair is compared and the result reported.
//   Channel skew (one side waiting too long) and repeated disagreement
//   (consecutive mismatches) latch a fault. The fault blocks all traffic until
//   clr is pulsed.
//
// Handshake: a word is transferred on a rising edge where valid and ready are
//   both high. ready depends only on registered state and rst, never on
//   valid. Data and valid are ignored while ready is low.
//
// Ports
//   clk                       rising-edge clock
//   rst                       asynchronous reset, active low
//   a_valid/a_data/a_ready    channel A word input
//   b_valid/b_data/b_ready    channel B word input
//   clr                       single-cycle clear of counters and fault
//   cmp_valid                 one-cycle pulse, one pair compared
//   cmp_match                 last compared pair was equal
//   cmp_data                  channel A word of the last compared pair
//   miss_cnt                  total mismatch count, saturating at 255
//   fault                     latched fault
//   fault_code                00 none, 01 mismatch limit, 10 skew timeout
module bus_compare_ctrl #(
  parameter int DW       = 16,
  parameter int DEPTH    = 4,
  parameter int TIMEOUT  = 255,
  parameter int MAX_MISS = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  input  logic          clr,
  output logic          cmp_valid,
  output logic          cmp_match,
  output logic [DW-1:0] cmp_data,
  output logic [7:0]    miss_cnt,
  output logic          fault,
  output logic [1:0]    fault_code
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);
  localparam logic [7:0]  MISS_M1    = 8'(MAX_MISS - 1);
  localparam logic [AW:0] FULL_CNT   = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CMP, S_FAULT} state_t;

  // state_q is the single place the controller state lives.
  state_t state_q, state_d;

  logic [DW-1:0] a_mem [DEPTH];
  logic [DW-1:0] b_mem [DEPTH];
  logic [AW-1:0] a_wp_q, a_rp_q, b_wp_q, b_rp_q;
  logic [AW:0]   a_cnt_q, b_cnt_q, a_cnt_nx, b_cnt_nx;
  logic          a_ne, b_ne, a_push, b_push, pop, flush, same, limit_hit;
  logic [15:0]   timer_q, timer_d;
  logic [7:0]    consec_q, miss_q;
  logic [1:0]    code_q, code_d;
  logic          cmp_valid_q, cmp_match_q;
  logic [DW-1:0] cmp_data_q;

  assign a_ne    = (a_cnt_q != '0);
  assign b_ne    = (b_cnt_q != '0);
  // Gating with rst keeps both channels stalled for the whole reset window.
  assign a_ready = rst && (a_cnt_q != FULL_CNT) && (state_q != S_FAULT);
  assign b_ready = rst && (b_cnt_q != FULL_CNT) && (state_q != S_FAULT);
  assign a_push  = a_valid && a_ready;
  assign b_push  = b_valid && b_ready;
  assign pop     = (state_q == S_CMP) && a_ne && b_ne;
  assign flush   = (state_q == S_FAULT) && clr;

  assign a_cnt_nx = a_cnt_q + {{AW{1'b0}}, a_push} - {{AW{1'b0}}, pop};
  assign b_cnt_nx = b_cnt_q + {{AW{1'b0}}, b_push} - {{AW{1'b0}}, pop};

  assign same = (a_mem[a_rp_q] == b_mem[b_rp_q]);
  // Uses the pre-clear streak, so a clr arriving with the limiting mismatch
  // still lets the fault through.
  assign limit_hit = pop && !same && (consec_q >= MISS_M1);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (a_ne && b_ne) begin
          state_d = S_CMP;
        end else if (a_ne || b_ne) begin
          state_d = S_WAIT;
          timer_d = '0;
        end
      end
      S_WAIT: begin
        if (a_ne && b_ne) begin
          state_d = S_CMP;
        end else if (!a_ne && !b_ne) begin
          state_d = S_IDLE;
        end else if (timer_q >= TIMEOUT_M1) begin
          // TIMEOUT full cycles spent here with one side empty.
          state_d = S_FAULT;
          code_d  = 2'b10;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_CMP: begin
        // Decide on post-pop occupancy so a steady stream stays here.
        if (limit_hit) begin
          state_d = S_FAULT;
          code_d  = 2'b01;
        end else if ((a_cnt_nx != '0) && (b_cnt_nx != '0)) begin
          state_d = S_CMP;
        end else if ((a_cnt_nx != '0) || (b_cnt_nx != '0)) begin
          state_d = S_WAIT;
          timer_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FAULT: begin
        if (clr) begin
          state_d = S_IDLE;
          timer_d = '0;
          code_d  = 2'b00;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      code_q  <= code_d;
    end
  end

  // Storage has no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (a_push) a_mem[a_wp_q] <= a_data;
    if (b_push) b_mem[b_wp_q] <= b_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_wp_q  <= '0;
      a_rp_q  <= '0;
      a_cnt_q <= '0;
      b_wp_q  <= '0;
      b_rp_q  <= '0;
      b_cnt_q <= '0;
    end else if (flush) begin
      a_wp_q  <= '0;
      a_rp_q  <= '0;
      a_cnt_q <= '0;
      b_wp_q  <= '0;
      b_rp_q  <= '0;
      b_cnt_q <= '0;
    end else begin
      if (a_push) a_wp_q <= a_wp_q + AW'(1);
      if (b_push) b_wp_q <= b_wp_q + AW'(1);
      if (pop) begin
        a_rp_q <= a_rp_q + AW'(1);
        b_rp_q <= b_rp_q + AW'(1);
      end
      a_cnt_q <= a_cnt_nx;
      b_cnt_q <= b_cnt_nx;
    end
  end

  // clr has priority over a same-cycle compare for both counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      consec_q <= '0;
      miss_q   <= '0;
    end else if (clr) begin
      consec_q <= '0;
      miss_q   <= '0;
    end else if (pop) begin
      if (same) begin
        consec_q <= '0;
      end else begin
        consec_q <= consec_q + 8'd1;
        if (miss_q != 8'hFF) miss_q <= miss_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_valid_q <= 1'b0;
      cmp_match_q <= 1'b0;
      cmp_data_q  <= '0;
    end else begin
      cmp_valid_q <= pop;
      if (pop) begin
        cmp_match_q <= same;
        cmp_data_q  <= a_mem[a_rp_q];
      end
    end
  end

  assign cmp_valid  = cmp_valid_q;
  assign cmp_match  = cmp_match_q;
  assign cmp_data   = cmp_data_q;
  assign miss_cnt   = miss_q;
  assign fault      = (state_q == S_FAULT);
  assign fault_code = code_q;

endmodule

// File: tb/tb_bus_compare_ctrl.sv
// Bench for bus_compare_ctrl: table of single-pair vectors, directed
// multi-cycle sequences (stream, skew, backpressure, saturation, async reset)
// and a randomized phase scored against a pairing model.
module tb_bus_compare_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, clr;
  logic [15:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        cmp_valid, cmp_match, fault;
  logic [15:0] cmp_data;
  logic [7:0]  miss_cnt;
  logic [1:0]  fault_code;

  int n_checks = 0;
  int n_fail   = 0;

  bus_compare_ctrl #(.DW(16), .DEPTH(4), .TIMEOUT(8), .MAX_MISS(3)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .clr(clr),
    .cmp_valid(cmp_valid), .cmp_match(cmp_match), .cmp_data(cmp_data),
    .miss_cnt(miss_cnt), .fault(fault), .fault_code(fault_code)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  int          pulse_i [$];
  logic [15:0] pulse_d [$];
  logic        pulse_m [$];
  logic        ar_hist [64];

  // Channel x sends nx words on cycles x0..x0+nx-1; word k = base*(k+1),
  // channel B words additionally XORed with bx. Compare pulses are logged.
  task automatic run_streams(input int na, input int a0, input int nb, input int b0,
                             input int ncyc, input logic [15:0] base, input logic [15:0] bx);
    pulse_i.delete();
    pulse_d.delete();
    pulse_m.delete();
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (cmp_valid) begin
        pulse_i.push_back(i);
        pulse_d.push_back(cmp_data);
        pulse_m.push_back(cmp_match);
      end
      ar_hist[i] = a_ready;
      a_valid = (i >= a0) && (i < a0 + na);
      a_data  = a_valid ? 16'(base * (i - a0 + 1)) : 16'h0;
      if (a_valid) check("a_accept", 32'(a_ready), 32'd1);
      b_valid = (i >= b0) && (i < b0 + nb);
      b_data  = b_valid ? (16'(base * (i - b0 + 1)) ^ bx) : 16'h0;
      if (b_valid) check("b_accept", 32'(b_ready), 32'd1);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_fault", 32'(fault), 32'd0);
    check("clr_code", 32'(fault_code), 32'd0);
    check("clr_miss", 32'(miss_cnt), 32'd0);
    check("clr_a_ready", 32'(a_ready), 32'd1);
    check("clr_b_ready", 32'(b_ready), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        match;
    logic [7:0]  miss;
    logic        flt;
    logic        clr_after;
  } vec_t;
  vec_t vt [12];

  // ---------------- scoreboard / model ----------------
  logic [15:0] qa [$];
  logic [15:0] qb [$];
  logic [16:0] exp_q [$];   // {match, a word}
  logic [15:0] wa [1024];
  logic [15:0] wb [1024];

  initial begin
    int stale, faults, stalls, ia, ib, lim, lag_a, lag_b, m_miss, m_consec, cyc;
    bit done;
    logic [16:0] e;
    logic [15:0] x, y;

    vt[0]  = '{16'h1111, 16'h1111, 1'b1, 8'd0, 1'b0, 1'b0};
    vt[1]  = '{16'h2222, 16'h2222, 1'b1, 8'd0, 1'b0, 1'b0};
    vt[2]  = '{16'h3333, 16'h3333, 1'b1, 8'd0, 1'b0, 1'b0};
    vt[3]  = '{16'h0001, 16'h0001, 1'b1, 8'd0, 1'b0, 1'b0};
    vt[4]  = '{16'h0002, 16'h0003, 1'b0, 8'd1, 1'b0, 1'b0};
    vt[5]  = '{16'h0004, 16'h0005, 1'b0, 8'd2, 1'b0, 1'b0};
    vt[6]  = '{16'h0006, 16'h0007, 1'b0, 8'd3, 1'b1, 1'b1};
    vt[7]  = '{16'h0001, 16'h0001, 1'b1, 8'd0, 1'b0, 1'b0};
    vt[8]  = '{16'h0002, 16'h0003, 1'b0, 8'd1, 1'b0, 1'b0};
    vt[9]  = '{16'h0004, 16'h0005, 1'b0, 8'd2, 1'b0, 1'b0};
    vt[10] = '{16'h0008, 16'h0008, 1'b1, 8'd2, 1'b0, 1'b0};
    vt[11] = '{16'h0006, 16'h0007, 1'b0, 8'd3, 1'b0, 1'b1};

    // ---------------- reset ----------------
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0; clr = 1'b0;
    a_data = '0; b_data = '0;
    #3;
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    check("rst_cmp_valid", 32'(cmp_valid), 32'd0);
    check("rst_cmp_data", 32'(cmp_data), 32'd0);
    check("rst_miss", 32'(miss_cnt), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_code", 32'(fault_code), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_a_ready", 32'(a_ready), 32'd1);
    check("post_rst_b_ready", 32'(b_ready), 32'd1);

    // ---------------- table vectors ----------------
    for (int k = 0; k < 12; k++) begin
      run_streams(1, 0, 1, 0, 8, vt[k].a, vt[k].a ^ vt[k].b);
      check("tbl_pulses", 32'(pulse_i.size()), 32'd1);
      if (pulse_i.size() == 1) begin
        check("tbl_data", 32'(pulse_d[0]), 32'(vt[k].a));
        check("tbl_match", 32'(pulse_m[0]), 32'(vt[k].match));
      end
      check("tbl_miss", 32'(miss_cnt), 32'(vt[k].miss));
      check("tbl_fault", 32'(fault), 32'(vt[k].flt));
      if (vt[k].flt) begin
        check("tbl_code", 32'(fault_code), 32'd1);
        check("tbl_a_ready_flt", 32'(a_ready), 32'd0);
        check("tbl_b_ready_flt", 32'(b_ready), 32'd0);
      end
      if (vt[k].clr_after) do_clr();
    end

    // ---------------- matched stream, same cycles ----------------
    run_streams(3, 0, 3, 0, 10, 16'h1111, 16'h0);
    check("stream_pulses", 32'(pulse_i.size()), 32'd3);
    for (int k = 0; k < pulse_i.size(); k++) begin
      check("stream_data", 32'(pulse_d[k]), 32'(16'(16'h1111 * (k + 1))));
      check("stream_match", 32'(pulse_m[k]), 32'd1);
      if (k > 0) check("stream_spacing", 32'(pulse_i[k] - pulse_i[k-1]), 32'd1);
    end
    check("stream_miss", 32'(miss_cnt), 32'd0);
    check("stream_fault", 32'(fault), 32'd0);

    // ---------------- skew within limit ----------------
    run_streams(1, 0, 1, 5, 14, 16'hABCD, 16'h0);
    check("skew5_pulses", 32'(pulse_i.size()), 32'd1);
    if (pulse_i.size() == 1) begin
      check("skew5_data", 32'(pulse_d[0]), 32'hABCD);
      check("skew5_match", 32'(pulse_m[0]), 32'd1);
    end
    check("skew5_fault", 32'(fault), 32'd0);

    // ---------------- skew beyond limit ----------------
    run_streams(1, 0, 1, 9, 14, 16'hABCD, 16'h0);
    check("skew9_pulses", 32'(pulse_i.size()), 32'd0);
    check("skew9_fault", 32'(fault), 32'd1);
    check("skew9_code", 32'(fault_code), 32'd2);
    check("skew9_a_ready", 32'(a_ready), 32'd0);
    check("skew9_b_ready", 32'(b_ready), 32'd0);
    do_clr();
    run_streams(1, 0, 1, 0, 8, 16'h0BEE, 16'h0);
    check("recover_pulses", 32'(pulse_i.size()), 32'd1);
    if (pulse_i.size() == 1) begin
      check("recover_data", 32'(pulse_d[0]), 32'h0BEE);
      check("recover_match", 32'(pulse_m[0]), 32'd1);
    end

    // ---------------- backpressure ----------------
    run_streams(4, 0, 4, 4, 16, 16'h0010, 16'h0);
    check("bp_a_full", 32'(ar_hist[4]), 32'd0);
    check("bp_pulses", 32'(pulse_i.size()), 32'd4);
    for (int k = 0; k < pulse_i.size(); k++) begin
      check("bp_data", 32'(pulse_d[k]), 32'(16'(16'h0010 * (k + 1))));
      check("bp_match", 32'(pulse_m[k]), 32'd1);
      if (k > 0) check("bp_spacing", 32'(pulse_i[k] - pulse_i[k-1]), 32'd1);
    end
    check("bp_a_ready_back", 32'(a_ready), 32'd1);
    check("bp_fault", 32'(fault), 32'd0);

    // ---------------- miss_cnt saturation ----------------
    stalls = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (!(a_ready && b_ready)) stalls++;
      a_valid = 1'b1;
      b_valid = 1'b1;
      a_data  = 16'(k);
      b_data  = 16'(k) ^ (((k % 2) == 1) ? 16'h8000 : 16'h0000);
    end
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("sat_stalls", 32'(stalls), 32'd0);
    check("sat_miss", 32'(miss_cnt), 32'd255);
    check("sat_fault", 32'(fault), 32'd0);

    // ---------------- async reset mid-stream ----------------
    run_streams(2, 0, 0, 0, 3, 16'h0777, 16'h0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_cmp_valid", 32'(cmp_valid), 32'd0);
    check("arst_cmp_match", 32'(cmp_match), 32'd0);
    check("arst_cmp_data", 32'(cmp_data), 32'd0);
    check("arst_miss", 32'(miss_cnt), 32'd0);
    check("arst_fault", 32'(fault), 32'd0);
    check("arst_code", 32'(fault_code), 32'd0);
    check("arst_a_ready", 32'(a_ready), 32'd0);
    check("arst_b_ready", 32'(b_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    stale = 0;
    faults = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cmp_valid) stale++;
      if (fault) faults++;
    end
    check("arst_stale_pulses", 32'(stale), 32'd0);
    check("arst_no_timeout", 32'(faults), 32'd0);
    run_streams(1, 0, 1, 0, 8, 16'h5A5A, 16'h0);
    check("arst_new_pulses", 32'(pulse_i.size()), 32'd1);
    if (pulse_i.size() == 1) begin
      check("arst_new_data", 32'(pulse_d[0]), 32'h5A5A);
      check("arst_new_match", 32'(pulse_m[0]), 32'd1);
    end

    // ---------------- randomized phase ----------------
    lim = 700;
    for (int k = 0; k < 1024; k++) begin
      wa[k] = 16'($urandom_range(0, 65535));
      wb[k] = ($urandom_range(0, 9) < 3) ? (wa[k] ^ 16'($urandom_range(1, 65535))) : wa[k];
    end
    ia = 0; ib = 0; lag_a = 0; lag_b = 0;
    m_miss = 0; m_consec = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (cmp_valid) begin
        if (exp_q.size() == 0) begin
          check("rnd_extra_pulse", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rnd_data", 32'(cmp_data), 32'(e[15:0]));
          check("rnd_match", 32'(cmp_match), 32'(e[16]));
          if (e[16]) begin
            m_consec = 0;
          end else begin
            m_consec++;
            if (m_miss < 255) m_miss++;
          end
          check("rnd_miss", 32'(miss_cnt), 32'(m_miss));
          if (m_consec >= 3) begin
            check("rnd_fault", 32'(fault), 32'd1);
            check("rnd_code", 32'(fault_code), 32'd1);
            a_valid = 1'b0;
            b_valid = 1'b0;
            do_clr();
            qa.delete();
            qb.delete();
            exp_q.delete();
            m_miss = 0;
            m_consec = 0;
            ia = (ia > ib) ? ia : ib;
            ib = ia;
            lag_a = 0;
            lag_b = 0;
            continue;
          end else begin
            check("rnd_no_fault", 32'(fault), 32'd0);
          end
        end
      end
      // Keep skew short: a starved side is forced to send.
      lag_b = (qa.size() > 0 && qb.size() == 0) ? lag_b + 1 : 0;
      lag_a = (qb.size() > 0 && qa.size() == 0) ? lag_a + 1 : 0;
      a_valid = (ia < lim) && (($urandom_range(0, 3) != 0) || lag_a >= 2);
      b_valid = (ib < lim) && (($urandom_range(0, 3) != 0) || lag_b >= 2);
      a_data  = a_valid ? wa[ia] : 16'h0;
      b_data  = b_valid ? wb[ib] : 16'h0;
      if (a_valid && a_ready) begin
        qa.push_back(wa[ia]);
        ia++;
      end
      if (b_valid && b_ready) begin
        qb.push_back(wb[ib]);
        ib++;
      end
      while (qa.size() > 0 && qb.size() > 0) begin
        x = qa.pop_front();
        y = qb.pop_front();
        exp_q.push_back({(x == y), x});
      end
      done = (ia == lim) && (ib == lim) && (exp_q.size() == 0);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    check("rnd_drain", 32'(done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
